// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel push-button / switch debouncer.
// Each channel: 2-FF synchroniser, stability counter, registered debounced
// level and single-cycle rise/fall pulses.
// Optional long-press detection is compiled in with `define DEBOUNCE_BANK_HOLD_EN;
// without it the hold output is tied low.
module debounce_bank #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned THRESHOLD   = 600000,
    parameter logic        INIT_LEVEL  = 1'b0,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] signal,
    output logic [N_CH-1:0] debounced,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold
);

    localparam int unsigned CNT_W = $clog2(THRESHOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESHOLD);

`ifdef DEBOUNCE_BANK_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
`endif

    // Elaboration-time sanity checks on the configuration
    if ((N_CH < 1) || (N_CH > 32)) begin : g_bad_n_ch
        $error("debounce_bank: N_CH must be in 1..32");
    end
    if (THRESHOLD < 1) begin : g_bad_threshold
        $error("debounce_bank: THRESHOLD must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("debounce_bank: HOLD_CYCLES must be >= 1");
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic             r_deb;
        logic             r_rise;
        logic             r_fall;
        logic [CNT_W-1:0] r_cnt;

        logic             w_mismatch;
        logic             w_commit;
        logic [CNT_W-1:0] w_cnt_nxt;

        // Count consecutive mismatches; commit on the cycle after reaching THRESHOLD
        always_comb begin
            w_mismatch = r_sync2 ^ r_deb;
            w_commit   = 1'b0;
            w_cnt_nxt  = '0;
            if (w_mismatch) begin
                if (r_cnt == CNT_MAX) begin
                    w_commit = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end

        // Two-stage synchroniser for the asynchronous pin
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1 <= INIT_LEVEL;
                r_sync2 <= INIT_LEVEL;
            end else begin
                r_sync1 <= signal[gi];
                r_sync2 <= r_sync1;
            end
        end

        // Stability counter, committed level and edge pulses
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt  <= '0;
                r_deb  <= INIT_LEVEL;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_rise <= w_commit & r_sync2;
                r_fall <= w_commit & ~r_sync2;
                if (w_commit) begin
                    r_deb <= r_sync2;
                end
            end
        end

        assign debounced[gi] = r_deb;
        assign rise[gi]      = r_rise;
        assign fall[gi]      = r_fall;

`ifdef DEBOUNCE_BANK_HOLD_EN
        logic [HOLD_W-1:0] r_hold_cnt;
        logic              r_hold;
        logic [HOLD_W-1:0] w_hold_nxt;
        logic              w_hold_hit;

        // Long-press timer: restarts on a new press, saturates so it fires once
        always_comb begin
            w_hold_nxt = r_hold_cnt;
            if (!r_deb || (w_commit && r_sync2)) begin
                w_hold_nxt = '0;
            end else if (r_hold_cnt != HOLD_MAX) begin
                w_hold_nxt = r_hold_cnt + HOLD_W'(1);
            end
            w_hold_hit = (w_hold_nxt == HOLD_MAX) && (r_hold_cnt != HOLD_MAX);
        end

        // Hold counter and single-cycle hold pulse
        always_ff @(posedge clk) begin
            if (reset) begin
                r_hold_cnt <= '0;
                r_hold     <= 1'b0;
            end else begin
                r_hold_cnt <= w_hold_nxt;
                r_hold     <= w_hold_hit;
            end
        end

        assign hold[gi] = r_hold;
`else
        assign hold[gi] = 1'b0;
`endif
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel debouncer for push-buttons and switches.
- Each of N_CH asynchronous inputs gets:
  - a 2-FF synchroniser,
  - an independent stability counter,
  - a registered debounced level,
  - single-cycle press (rise) and release (fall) pulses.
- Sits between the board I/O pins and the control FSMs. It replaces per-button debouncer instances with one bank.

Parameters:
- N_CH, 4, number of independent channels (1..32).
- THRESHOLD, 600000, number of consecutive mismatched cycles before a change commits (>=1).
- INIT_LEVEL, 0, level of the synchronisers and debounced outputs after reset; one bit, applied to all channels.
- HOLD_CYCLES, 50000000, stable-high cycles before a hold pulse; used only with the optional feature.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- signal, input, N_CH, raw asynchronous inputs; bit i is channel i.
- debounced, output, N_CH, stable level per channel.
- rise, output, N_CH, 1-cycle pulse when debounced[i] goes 0->1.
- fall, output, N_CH, 1-cycle pulse when debounced[i] goes 1->0.
- hold, output, N_CH, 1-cycle long-press pulse; tied to 0 when the feature is out.

Behaviour:
- One clock; reset is synchronous and active-high. Every register below updates only on posedge clk.
- Reset (reset=1 at a clock edge):
  - both sync stages and debounced are set to INIT_LEVEL;
  - all counters are set to 0;
  - rise, fall and hold are set to 0.
  - Reset mid-count discards progress. No pulse is emitted at or after reset release, even if the input differs from INIT_LEVEL; such a difference is debounced normally afterwards.
- Counter width: $clog2(THRESHOLD+1) bits per channel. The counter never exceeds THRESHOLD and never wraps.
- Per channel i, each cycle (sync2 = second sync stage):
  - sync2 == debounced: counter <= 0. Any glitch shorter than the threshold restarts the count.
  - sync2 != debounced and counter < THRESHOLD: counter <= counter+1.
  - sync2 != debounced and counter == THRESHOLD: debounced <= sync2 and counter <= 0.
- Commit timing: a change commits on the (THRESHOLD+1)-th consecutive mismatched cycle.
- Latency: for a clean step on signal[i] that is set up before edge k, debounced[i] changes at edge k+THRESHOLD+2. That is THRESHOLD+3 edges counting edge k.
- rise[i] / fall[i]:
  - registered, asserted in the same cycle debounced[i] takes its new value;
  - high for exactly one cycle;
  - never both high on the same channel in the same cycle.
- Channels are fully independent. Simultaneous commits on several channels produce simultaneous pulses.
- An input that toggles faster than THRESHOLD cycles never commits. The output holds its last value indefinitely.
- Outputs are driven directly from registers; there is no combinational path from signal.

Optional Feature:
- Macro: DEBOUNCE_BANK_HOLD_EN.
- Defined:
  - each channel has a hold counter of $clog2(HOLD_CYCLES+1) bits;
  - it clears to 0 on reset, when debounced[i]==0, and on the cycle rise[i] fires;
  - while debounced[i]==1 it increments, saturating at HOLD_CYCLES;
  - hold[i] pulses for one cycle on the cycle the counter reaches HOLD_CYCLES;
  - exactly one hold pulse per press, with no auto-repeat;
  - a release before HOLD_CYCLES produces no hold pulse.
- Not defined: the hold logic is absent and hold is constant 0.

Test Plan:
1. Reset release with INIT_LEVEL=0, signal=0, THRESHOLD=4, N_CH=4 -> debounced=0000; rise, fall and hold stay 0 for 20 cycles.
2. Clean step: signal[0] goes 0->1 and is held -> debounced[0]=1 exactly 7 edges after the first sampling edge; rise[0]=1 for that single cycle; fall=0.
3. Bounce: signal[1] alternates with high for 3 cycles and low for 1, for 40 cycles, then is held high -> no commit during the bounce; commit 7 edges after the final hold begins; exactly one rise[1].
4. Release: channel 0 high, then signal[0] goes to 0 -> debounced[0]=0 after 7 edges; fall[0]=1 for one cycle.
5. Simultaneous and mid-count reset:
   - channels 2 and 3 stepped on the same edge -> rise[2] and rise[3] pulse in the same cycle;
   - a separate step, with reset asserted 3 cycles in -> debounced returns to INIT_LEVEL with no pulse, then recommits 7 edges after reset deasserts.
6. With DEBOUNCE_BANK_HOLD_EN and HOLD_CYCLES=10:
   - press held 30 cycles -> a single hold pulse 10 cycles after rise;
   - press held 5 cycles -> no hold pulse.
